// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, GF(2^8) xtime, block/round constants, sequencer states.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int BLOCK_W    = 128;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_APPLY = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_REQ   = ST_REQ,
        S_WAIT  = ST_WAIT,
        S_APPLY = ST_APPLY,
        S_DONE  = ST_DONE
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_transform.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the final
// round), AddRoundKey. Byte 0 sits in bits 127:120, column c holds bytes 4c..4c+3.
module aes_round_transform
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] key,
    input  logic               final_round,
    output logic [BLOCK_W-1:0] result
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state[127-8*i -: 8]];
        end
        // Row r of column c takes the byte from column (c+r) mod 4
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        result = '0;
        for (int i = 0; i < 16; i++) begin
            result[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor that steps an external round-key expander through rounds 0..10.
// Optional debug taps (po_dbg_state, po_dbg_valid) are built when AES_SEQ_DEBUG_EN is defined.
//   state | meaning
//   IDLE  | waiting for pi_start, outputs quiet
//   REQ   | po_update_key strobe for the current round
//   WAIT  | KEY_LAT-1 cycles for the expander to respond (skipped when KEY_LAT=1)
//   APPLY | fold pi_round_key into the block state
//   DONE  | ciphertext valid, po_done pulse
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int KEY_LAT = 2
)
(
    input  logic               pi_clk,
    input  logic               pi_rst,
    input  logic               pi_start,
    input  logic [BLOCK_W-1:0] pi_plaintext,
    input  logic [BLOCK_W-1:0] pi_key,
    input  logic [BLOCK_W-1:0] pi_round_key,
    output logic [BLOCK_W-1:0] po_cipher_key,
    output logic [3:0]         po_current_round,
    output logic               po_update_key,
    output logic [BLOCK_W-1:0] po_ciphertext,
    output logic               po_busy,
    output logic               po_done
`ifdef AES_SEQ_DEBUG_EN
    ,
    output logic [BLOCK_W-1:0] po_dbg_state,
    output logic               po_dbg_valid
`endif
);

    localparam logic [2:0] WAIT_LOAD  = (KEY_LAT > 1) ? 3'(KEY_LAT - 2) : 3'd0;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    aes_state_e         fsm_q;
    logic [3:0]         round_q;
    logic [2:0]         wait_q;
    logic [BLOCK_W-1:0] blk_q;
    logic [BLOCK_W-1:0] key_q;
    logic [BLOCK_W-1:0] ct_q;
    logic [BLOCK_W-1:0] xform_res;
    logic [BLOCK_W-1:0] apply_res;

    aes_round_transform u_round (
        .state       (blk_q),
        .key         (pi_round_key),
        .final_round (round_q == LAST_ROUND),
        .result      (xform_res)
    );

    // Round 0 is a bare AddRoundKey
    assign apply_res = (round_q == 4'd0) ? (blk_q ^ pi_round_key) : xform_res;

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            fsm_q   <= S_IDLE;
            round_q <= '0;
            wait_q  <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            ct_q    <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (pi_start) begin
                        blk_q   <= pi_plaintext;
                        key_q   <= pi_key;
                        round_q <= '0;
                        fsm_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (KEY_LAT > 1) begin
                        wait_q <= WAIT_LOAD;
                        fsm_q  <= S_WAIT;
                    end else begin
                        fsm_q  <= S_APPLY;
                    end
                end
                S_WAIT: begin
                    if (wait_q == '0) fsm_q <= S_APPLY;
                    else              wait_q <= wait_q - 3'd1;
                end
                S_APPLY: begin
                    blk_q <= apply_res;
                    if (round_q == LAST_ROUND) begin
                        ct_q    <= apply_res;
                        round_q <= '0;
                        fsm_q   <= S_DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                        fsm_q   <= S_REQ;
                    end
                end
                S_DONE:  fsm_q <= S_IDLE;
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign po_cipher_key    = key_q;
    assign po_current_round = round_q;
    assign po_update_key    = (fsm_q == S_REQ);
    assign po_ciphertext    = ct_q;
    assign po_busy          = (fsm_q == S_REQ) || (fsm_q == S_WAIT) || (fsm_q == S_APPLY);
    assign po_done          = (fsm_q == S_DONE);

`ifdef AES_SEQ_DEBUG_EN
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            po_dbg_state <= '0;
            po_dbg_valid <= 1'b0;
        end else begin
            po_dbg_valid <= (fsm_q == S_APPLY);
            if (fsm_q == S_APPLY) po_dbg_state <= apply_res;
        end
    end
`endif

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption engine that sits directly downstream of the round-key expander and drives it. It latches a plaintext block and a cipher key and steps the expander through rounds 0–10 with a round index and an update strobe. Each returned round key is applied to the block state: AddRoundKey for round 0, a full round for 1–9, and the final round (no MixColumns) for 10. The ciphertext is presented with a one-cycle done pulse.

## Interface
- KEY_LAT, 2, cycles from the po_update_key pulse until pi_round_key holds that round's key (legal range 1–7)
- pi_clk  in  1  clock; all logic on rising edge
- pi_rst  in  1  reset, synchronous, active-high
- pi_start  in  1  request; accepted only in IDLE
- pi_plaintext  in  128  block; sampled on the accepted start
- pi_key  in  128  cipher key; sampled on the accepted start
- pi_round_key  in  128  round key returned by the expander
- po_cipher_key  out  128  latched key, fed to the expander's input key
- po_current_round  out  4  round index to the expander
- po_update_key  out  1  one-cycle strobe per round request
- po_ciphertext  out  128  result; holds until the next accepted start
- po_busy  out  1  high from start acceptance through the final APPLY
- po_done  out  1  one-cycle pulse when po_ciphertext becomes valid

## Operation
- FSM states:
  - IDLE: on pi_start, latch plaintext and key, set round=0, then go to REQ.
  - REQ: po_update_key=1 for one cycle, then go to WAIT.
  - WAIT: count KEY_LAT-1 cycles, then go to APPLY. If KEY_LAT=1, WAIT is skipped.
  - APPLY: sample pi_round_key and update the state register:
    - round 0: state ^= key
    - rounds 1–9: MixColumns(ShiftRows(SubBytes(state))) ^ key
    - round 10: ShiftRows(SubBytes(state)) ^ key
  - After APPLY: if round<10, increment round and go to REQ. If round=10, go to DONE.
  - DONE: load po_ciphertext, pulse po_done, return to IDLE.
- po_current_round holds the round value from REQ through APPLY. It is 0 in IDLE.
- Byte order: bit 127 is byte 0. Column c is bytes 4c..4c+3, following the FIPS-197 column-major layout.
- pi_start while busy is ignored, with no queuing. A start in the same cycle as DONE is also ignored; it is accepted only in IDLE.
- pi_rst mid-operation aborts the encryption. The partial state is discarded, po_done is not pulsed, and po_ciphertext returns to 0.

## Timing
- Reset values: all outputs 0, FSM in IDLE, state register 0, latched key 0.
- A start accepted at edge T enters REQ for round 0 in cycle T+1.
- Each round takes 1+KEY_LAT cycles (REQ plus KEY_LAT-1 WAIT cycles plus APPLY).
- po_done is asserted 11·(KEY_LAT+1)+1 cycles after the accepting edge; with KEY_LAT=2 that is 34 cycles.
- The next start is accepted one cycle after po_done.
- po_busy falls in the same cycle po_done rises.
- pi_round_key is sampled only in APPLY and is don't-care at all other times.

## Configuration
- AES_SEQ_DEBUG_EN defined: adds the following outputs, all reset to 0:
  - po_dbg_state[127:0]: state register after each APPLY
  - po_dbg_valid: one-cycle pulse coincident with each APPLY result, 11 pulses per block
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - the S-box as a 256×8 constant array
  - the xtime function
  - constants NUM_ROUNDS=10, BLOCK_W=128
  - the FSM state enum
- Sub-module aes_round_transform: a combinational block with inputs state, key, and final flag. It produces the SubBytes→ShiftRows→(MixColumns unless final)→AddRoundKey result. The sequencer muxes in a plain XOR for round 0.

## Test plan
- Plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, with an expander model at KEY_LAT=2 → po_ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, po_done at +34 cycles.
- Plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → ciphertext 3925841d02dc09fbdc118597196a0b32. With AES_SEQ_DEBUG_EN, the round-1 dbg_state is a49c7ff2689f352b6b5bea43026a5049.
- pi_start held high for 40 cycles → exactly one done pulse within the first 34 cycles, then a second encryption starts in the cycle after done.
- pi_rst asserted during round 5 APPLY → next cycle all outputs are 0 and the FSM is in IDLE. A subsequent start yields the correct ciphertext.
- Sweep KEY_LAT over 1 and 7 → correct ciphertext at 23 and 89 cycles respectively. po_update_key pulses exactly 11 times, with po_current_round 0..10.
- Expander model drives garbage on pi_round_key outside APPLY → ciphertext unaffected.
